// File: rtl/md5_block_engine.sv
// ---------------------------------------------------------------------------
// md5_block_engine
//
// MD5 compression engine for a stream of pre-padded 512-bit blocks. The
// chaining value is carried across blocks and a digest is produced once the
// block marked in_last has been compressed. ROUNDS_PER_CLK MD5 rounds are
// evaluated per clock as a combinational chain.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   init       reload chaining value with the MD5 IV (honoured only in IDLE)
//   in_valid   block_in / in_last valid
//   in_ready   engine can accept a block (IDLE only)
//   block_in   padded block, message byte k at bits [8k+7:8k]
//   in_last    block is the final block of the message
//   out_valid  digest valid, held until out_ready
//   out_ready  downstream accepts digest
//   digest     canonical MD5 bytes, A at [31:0] .. D at [127:96]
//   busy       high while compressing (ROUND or ADD)
//   block_cnt  blocks compressed since last init / digest transfer
// ---------------------------------------------------------------------------
module md5_block_engine #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest,
    output logic         busy,
    output logic [15:0]  block_cnt
);

    generate
        if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4 ||
              ROUNDS_PER_CLK == 8 || ROUNDS_PER_CLK == 16)) begin : g_bad_rpc
            $error("md5_block_engine: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Chaining state layout matches the digest: {D, C, B, A}
    localparam logic [127:0] IV       = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [5:0]   STEP     = 6'(ROUNDS_PER_CLK);
    localparam logic [5:0]   LAST_RND = 6'(64 - ROUNDS_PER_CLK);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_OUT} state_t;

    function automatic logic [31:0] k_rom(input logic [5:0] t);
        k_rom = '0;
        case (t)
            6'd0:  k_rom = 32'hd76aa478; 6'd1:  k_rom = 32'he8c7b756; 6'd2:  k_rom = 32'h242070db; 6'd3:  k_rom = 32'hc1bdceee;
            6'd4:  k_rom = 32'hf57c0faf; 6'd5:  k_rom = 32'h4787c62a; 6'd6:  k_rom = 32'ha8304613; 6'd7:  k_rom = 32'hfd469501;
            6'd8:  k_rom = 32'h698098d8; 6'd9:  k_rom = 32'h8b44f7af; 6'd10: k_rom = 32'hffff5bb1; 6'd11: k_rom = 32'h895cd7be;
            6'd12: k_rom = 32'h6b901122; 6'd13: k_rom = 32'hfd987193; 6'd14: k_rom = 32'ha679438e; 6'd15: k_rom = 32'h49b40821;
            6'd16: k_rom = 32'hf61e2562; 6'd17: k_rom = 32'hc040b340; 6'd18: k_rom = 32'h265e5a51; 6'd19: k_rom = 32'he9b6c7aa;
            6'd20: k_rom = 32'hd62f105d; 6'd21: k_rom = 32'h02441453; 6'd22: k_rom = 32'hd8a1e681; 6'd23: k_rom = 32'he7d3fbc8;
            6'd24: k_rom = 32'h21e1cde6; 6'd25: k_rom = 32'hc33707d6; 6'd26: k_rom = 32'hf4d50d87; 6'd27: k_rom = 32'h455a14ed;
            6'd28: k_rom = 32'ha9e3e905; 6'd29: k_rom = 32'hfcefa3f8; 6'd30: k_rom = 32'h676f02d9; 6'd31: k_rom = 32'h8d2a4c8a;
            6'd32: k_rom = 32'hfffa3942; 6'd33: k_rom = 32'h8771f681; 6'd34: k_rom = 32'h6d9d6122; 6'd35: k_rom = 32'hfde5380c;
            6'd36: k_rom = 32'ha4beea44; 6'd37: k_rom = 32'h4bdecfa9; 6'd38: k_rom = 32'hf6bb4b60; 6'd39: k_rom = 32'hbebfbc70;
            6'd40: k_rom = 32'h289b7ec6; 6'd41: k_rom = 32'heaa127fa; 6'd42: k_rom = 32'hd4ef3085; 6'd43: k_rom = 32'h04881d05;
            6'd44: k_rom = 32'hd9d4d039; 6'd45: k_rom = 32'he6db99e5; 6'd46: k_rom = 32'h1fa27cf8; 6'd47: k_rom = 32'hc4ac5665;
            6'd48: k_rom = 32'hf4292244; 6'd49: k_rom = 32'h432aff97; 6'd50: k_rom = 32'hab9423a7; 6'd51: k_rom = 32'hfc93a039;
            6'd52: k_rom = 32'h655b59c3; 6'd53: k_rom = 32'h8f0ccc92; 6'd54: k_rom = 32'hffeff47d; 6'd55: k_rom = 32'h85845dd1;
            6'd56: k_rom = 32'h6fa87e4f; 6'd57: k_rom = 32'hfe2ce6e0; 6'd58: k_rom = 32'ha3014314; 6'd59: k_rom = 32'h4e0811a1;
            6'd60: k_rom = 32'hf7537e82; 6'd61: k_rom = 32'hbd3af235; 6'd62: k_rom = 32'h2ad7d2bb; 6'd63: k_rom = 32'heb86d391;
            default: k_rom = '0;
        endcase
    endfunction

    // Rotate amount depends only on the round group and t mod 4
    function automatic logic [4:0] s_rom(input logic [5:0] t);
        s_rom = 5'd0;
        case ({t[5:4], t[1:0]})
            4'd0:  s_rom = 5'd7;  4'd1:  s_rom = 5'd12; 4'd2:  s_rom = 5'd17; 4'd3:  s_rom = 5'd22;
            4'd4:  s_rom = 5'd5;  4'd5:  s_rom = 5'd9;  4'd6:  s_rom = 5'd14; 4'd7:  s_rom = 5'd20;
            4'd8:  s_rom = 5'd4;  4'd9:  s_rom = 5'd11; 4'd10: s_rom = 5'd16; 4'd11: s_rom = 5'd23;
            4'd12: s_rom = 5'd6;  4'd13: s_rom = 5'd10; 4'd14: s_rom = 5'd15; 4'd15: s_rom = 5'd21;
            default: s_rom = 5'd0;
        endcase
    endfunction

    // Message word index; only t mod 16 matters, so 4-bit wrap gives the % 16
    function automatic logic [3:0] g_idx(input logic [5:0] t);
        logic [3:0] w;
        w = t[3:0];
        g_idx = w;
        case (t[5:4])
            2'd0: g_idx = w;
            2'd1: g_idx = w * 4'd5 + 4'd1;
            2'd2: g_idx = w * 4'd3 + 4'd5;
            2'd3: g_idx = w * 4'd7;
            default: g_idx = w;
        endcase
    endfunction

    function automatic logic [127:0] md5_round(input logic [127:0] st, input logic [5:0] t,
                                               input logic [511:0] m);
        logic [31:0] a, b, c, d, f, sum, rot;
        logic [4:0]  s;
        logic [3:0]  g;
        a = st[31:0];
        b = st[63:32];
        c = st[95:64];
        d = st[127:96];
        f = '0;
        case (t[5:4])
            2'd0: f = (b & c) | (~b & d);
            2'd1: f = (d & b) | (~d & c);
            2'd2: f = b ^ c ^ d;
            2'd3: f = c ^ (b | ~d);
            default: f = '0;
        endcase
        g   = g_idx(t);
        s   = s_rom(t);
        sum = a + f + k_rom(t) + m[{g, 5'd0} +: 32];
        rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
        // A<-D, B<-B+rot, C<-B, D<-C
        md5_round = {c, b, b + rot, d};
    endfunction

    state_t         r_state;
    logic [127:0]   r_h;
    logic [127:0]   r_work;
    logic [511:0]   r_block;
    logic           r_last;
    logic [5:0]     r_round;
    logic           r_out_valid;
    logic [127:0]   r_digest;
    logic           r_busy;
    logic [15:0]    r_cnt;

    logic [127:0]   w_next;
    logic [127:0]   w_sum;

    always_comb begin
        w_next = r_work;
        for (int unsigned i = 0; i < ROUNDS_PER_CLK; i++) begin
            w_next = md5_round(w_next, r_round + 6'(i), r_block);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            w_sum[32*j +: 32] = r_h[32*j +: 32] + r_work[32*j +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_h         <= IV;
            r_work      <= '0;
            r_block     <= '0;
            r_last      <= 1'b0;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_digest    <= '0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (init) begin
                        r_h   <= IV;
                        r_cnt <= '0;
                    end
                    if (in_valid) begin
                        r_block <= block_in;
                        r_last  <= in_last;
                        // init in the accept cycle must compress from IV
                        r_work  <= init ? IV : r_h;
                        r_round <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_work  <= w_next;
                    r_round <= r_round + STEP;
                    if (r_round == LAST_RND) begin
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_h    <= w_sum;
                    r_cnt  <= r_cnt + 16'd1;
                    r_busy <= 1'b0;
                    if (r_last) begin
                        r_digest    <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_h         <= IV;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so the engine never advertises readiness while held in reset
    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign digest    = r_digest;
    assign busy      = r_busy;
    assign block_cnt = r_cnt;

endmodule

// File: tb/tb_md5_block_engine.sv
module tb_md5_block_engine;

    localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] DIG_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] DIG_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic         clk = 1'b0;
    logic         reset, init, in_valid, in_last, out_ready;
    logic [511:0] block_in;
    logic         in_ready_v  [5];
    logic         out_valid_v [5];
    logic         busy_v      [5];
    logic [127:0] digest_v    [5];
    logic [15:0]  cnt_v       [5];

    logic [511:0] blk_empty, blk_abc, blk_a, blk_pad2;
    logic [127:0] exp_two;

    int errors = 0;
    int checks = 0;
    int lat [5];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        md5_block_engine #(.ROUNDS_PER_CLK(1 << gi)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .init      (init),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[gi]),
            .block_in  (block_in),
            .in_last   (in_last),
            .out_valid (out_valid_v[gi]),
            .out_ready (out_ready),
            .digest    (digest_v[gi]),
            .busy      (busy_v[gi]),
            .block_cnt (cnt_v[gi])
        );
    end

    // Straight RFC 1321 compression of one block, state laid out as {D,C,B,A}
    function automatic logic [127:0] ref_md5(input logic [127:0] h, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, tmp;
        int g;
        a = h[31:0]; b = h[63:32]; c = h[95:64]; d = h[127:96];
        for (int t = 0; t < 64; t++) begin
            if (t < 16)      begin f = (b & c) | (~b & d); g = t;              end
            else if (t < 32) begin f = (d & b) | (~d & c); g = (5 * t + 1) % 16; end
            else if (t < 48) begin f = b ^ c ^ d;          g = (3 * t + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * t) % 16;     end
            tmp = a + f + KT[t] + blk[32 * g +: 32];
            tmp = (tmp << SH[(t / 16) * 4 + t % 4]) | (tmp >> (32 - SH[(t / 16) * 4 + t % 4]));
            a = d; d = c; c = b; b = b + tmp;
        end
        return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    endfunction

    function automatic bit all_ready();
        return in_ready_v[0] && in_ready_v[1] && in_ready_v[2] && in_ready_v[3] && in_ready_v[4];
    endfunction

    task automatic wait_all_ready(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!all_ready() && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!all_ready()) begin
            errors++;
            $display("FAIL wait_ready: in_ready not all high after %0d cycles", max_cyc);
        end
    endtask

    // Presents a block from a negedge; returns 1ns after the accept edge
    task automatic send_block(input logic [511:0] blk, input logic last, input logic with_init);
        wait_all_ready(200);
        block_in = blk;
        in_last  = last;
        init     = with_init;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        init     = 1'b0;
    endtask

    // lat[i] = number of edges after accept until out_valid first seen (0 = never)
    task automatic wait_out(input int max_cyc);
        for (int i = 0; i < 5; i++) lat[i] = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++) if (out_valid_v[i] && lat[i] == 0) lat[i] = c;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0 && lat[4] != 0) break;
        end
    endtask

    task automatic pop_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; block_in = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b0 || out_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0 ||
                digest_v[i] !== '0 || cnt_v[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset_vals[%0d]: rdy=%b ov=%b busy=%b dig=%h cnt=%h, want 0/0/0/0/0",
                         i, in_ready_v[i], out_valid_v[i], busy_v[i], digest_v[i], cnt_v[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready_v[0]);
        end
    endtask

    task automatic test_empty();
        send_block(blk_empty, 1'b1, 1'b0);
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL empty_busy: got %b want 1", busy_v[0]);
        end
        wait_out(80);
        checks++;
        if (lat[0] != 65) begin
            errors++;
            $display("FAIL empty_latency: got %0d want 65", lat[0]);
        end
        checks++;
        if (digest_v[0] !== DIG_EMPTY) begin
            errors++;
            $display("FAIL empty_digest: got %h want %h", digest_v[0], DIG_EMPTY);
        end
        checks++;
        if (cnt_v[0] !== 16'd1 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL empty_cnt_busy: cnt=%0d busy=%b want 1/0", cnt_v[0], busy_v[0]);
        end
        pop_out();
        checks++;
        if (out_valid_v[0] !== 1'b0 || cnt_v[0] !== 16'd0) begin
            errors++;
            $display("FAIL empty_pop: ov=%b cnt=%0d want 0/0", out_valid_v[0], cnt_v[0]);
        end
    endtask

    task automatic test_abc_all_r();
        send_block(blk_abc, 1'b1, 1'b0);
        wait_out(80);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (lat[i] != (64 >> i) + 1) begin
                errors++;
                $display("FAIL abc_latency[R=%0d]: got %0d want %0d", 1 << i, lat[i], (64 >> i) + 1);
            end
            checks++;
            if (digest_v[i] !== DIG_ABC) begin
                errors++;
                $display("FAIL abc_digest[R=%0d]: got %h want %h", 1 << i, digest_v[i], DIG_ABC);
            end
        end
        pop_out();
    endtask

    task automatic test_two_block();
        int seen;
        seen = 0;
        send_block(blk_a, 1'b0, 1'b0);
        for (int c = 0; c < 70; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++) if (out_valid_v[i] !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL two_blk_no_out: out_valid seen %0d times want 0", seen);
        end
        checks++;
        if (cnt_v[0] !== 16'd1) begin
            errors++;
            $display("FAIL two_blk_cnt1: got %0d want 1", cnt_v[0]);
        end
        send_block(blk_pad2, 1'b1, 1'b0);
        wait_out(80);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (digest_v[i] !== exp_two || cnt_v[i] !== 16'd2) begin
                errors++;
                $display("FAIL two_blk[R=%0d]: dig=%h cnt=%0d want %h cnt=2", 1 << i, digest_v[i], cnt_v[i], exp_two);
            end
        end
        pop_out();
    endtask

    task automatic test_backpressure();
        int bad_rdy, bad_dig;
        bad_rdy = 0;
        bad_dig = 0;
        send_block(blk_abc, 1'b1, 1'b0);
        wait_out(80);
        @(negedge clk);
        block_in = blk_abc; in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (in_ready_v[0] !== 1'b0) bad_rdy++;
            if (digest_v[0] !== DIG_ABC || out_valid_v[0] !== 1'b1) bad_dig++;
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL bp_ready_low: in_ready high in %0d of 20 cycles, want 0", bad_rdy);
        end
        checks++;
        if (bad_dig != 0) begin
            errors++;
            $display("FAIL bp_hold: digest/out_valid disturbed in %0d of 20 cycles, want 0", bad_dig);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_transfer: ov=%b rdy=%b want 0/1", out_valid_v[0], in_ready_v[0]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(80);
        checks++;
        if (lat[0] != 65 || digest_v[0] !== DIG_ABC) begin
            errors++;
            $display("FAIL bp_next_abc: lat=%0d dig=%h want 65 %h", lat[0], digest_v[0], DIG_ABC);
        end
        pop_out();
    endtask

    task automatic test_reset_mid();
        send_block(blk_abc, 1'b1, 1'b0);
        repeat (30) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || digest_v[i] !== '0 || cnt_v[i] !== 16'd0) begin
                errors++;
                $display("FAIL mid_reset[R=%0d]: ov=%b busy=%b dig=%h cnt=%0d want all 0",
                         1 << i, out_valid_v[i], busy_v[i], digest_v[i], cnt_v[i]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        send_block(blk_empty, 1'b1, 1'b0);
        wait_out(80);
        checks++;
        if (lat[0] != 65 || digest_v[0] !== DIG_EMPTY) begin
            errors++;
            $display("FAIL post_reset_empty: lat=%0d dig=%h want 65 %h", lat[0], digest_v[0], DIG_EMPTY);
        end
        pop_out();
    endtask

    task automatic test_init();
        // init pulses land while every engine is in ROUND or ADD
        send_block(blk_a, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        send_block(blk_pad2, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1 init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        wait_out(80);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (digest_v[i] !== exp_two) begin
                errors++;
                $display("FAIL init_ignored[R=%0d]: got %h want %h", 1 << i, digest_v[i], exp_two);
            end
        end
        pop_out();
        // init together with in_valid after a non-final block restarts from IV
        send_block(blk_a, 1'b0, 1'b0);
        send_block(blk_abc, 1'b1, 1'b1);
        wait_out(80);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (digest_v[i] !== DIG_ABC || cnt_v[i] !== 16'd1) begin
                errors++;
                $display("FAIL init_accept[R=%0d]: dig=%h cnt=%0d want %h cnt=1", 1 << i, digest_v[i], cnt_v[i], DIG_ABC);
            end
        end
        pop_out();
    endtask

    initial begin
        blk_empty = 512'h80;
        blk_abc   = (512'h18 << 448) | 512'h80636261;
        blk_a     = {64{8'h61}};
        blk_pad2  = (512'h02 << 456) | 512'h80;
        exp_two   = ref_md5(ref_md5(IV, blk_a), blk_pad2);

        test_reset();
        test_empty();
        test_abc_all_r();
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_init();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
